// File: rtl/config_regbank_pkg.sv
// config_regbank_pkg: shared definitions for the configuration/status register bank.
//   - Per-bit access-mode encoding (RW, RO, W1C) and a decoder that resolves mask precedence.
//   - reg_lsb(): locates register i inside a flat NUM_REGS*DATA_WIDTH vector, so that
//     register i is flat[reg_lsb(i, DATA_WIDTH) +: DATA_WIDTH].
package config_regbank_pkg;

  typedef enum logic [1:0] {
    AccRw  = 2'd0,
    AccRo  = 2'd1,
    AccW1c = 2'd2
  } acc_mode_e;

  // RO takes precedence over W1C when both mask bits are set.
  function automatic acc_mode_e bit_mode(input logic ro, input logic w1c);
    if (ro) begin
      return AccRo;
    end else if (w1c) begin
      return AccW1c;
    end
    return AccRw;
  endfunction

  function automatic int unsigned reg_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/config_regbank_if.sv
// config_regbank_if: host-side write/read bus of the register bank.
//   master: drives write requests (wr_valid/addr/data/strb) and read requests (rd_req/addr);
//           receives wr_err, rd_valid, rd_data, rd_err.
//   slave : the register bank side of the same signals.
interface config_regbank_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                    wr_valid;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    wr_err;
  logic                    rd_req;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    rd_valid;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_err;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_strb, rd_req, rd_addr,
    input  wr_err, rd_valid, rd_data, rd_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_strb, rd_req, rd_addr,
    output wr_err, rd_valid, rd_data, rd_err
  );
endinterface

// File: rtl/config_regbank_cell.sv
// config_regbank_cell: one DATA_WIDTH register with per-bit access modes.
//   clk, reset   : clock, asynchronous active-high reset (loads RESET_VALUE)
//   sw_we_i      : software write addressed to this register
//   wr_data_i    : software write data;  wr_strb_i: byte-lane enables
//   hw_set_i     : per-bit set pulses (W1C bits only)
//   hw_we_i      : hardware update enable; hw_wdata_i: update data (RO bits only)
//   q_o          : current register contents
module config_regbank_cell
  import config_regbank_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] W1C_MASK    = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sw_we_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
  input  logic [DATA_WIDTH-1:0]   hw_set_i,
  input  logic                    hw_we_i,
  input  logic [DATA_WIDTH-1:0]   hw_wdata_i,
  output logic [DATA_WIDTH-1:0]   q_o
);

  logic [DATA_WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
      case (bit_mode(RO_MASK[b], W1C_MASK[b]))
        AccRw: begin
          if (sw_we_i && wr_strb_i[b/8]) q_d[b] = wr_data_i[b];
        end
        AccW1c: begin
          if (sw_we_i && wr_strb_i[b/8] && wr_data_i[b]) q_d[b] = 1'b0;
          // Set is applied after the clear so a coincident event is never lost.
          if (hw_set_i[b]) q_d[b] = 1'b1;
        end
        AccRo: begin
          if (hw_we_i) q_d[b] = hw_wdata_i[b];
        end
        default: q_d[b] = q_q[b];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/config_regbank.sv
// config_regbank: configuration/status register bank.
//   clk, reset   : clock, asynchronous active-high reset
//   bus          : host write/read bus (slave side), 1-cycle read latency, wr_err/rd_err flags
//   hw_set_i     : flat per-bit set pulses for W1C bits
//   hw_we_i      : per-register hardware update enable for RO bits; hw_wdata_i: update data
//   mem_expose_o : flat view of every register (register i at [i*DATA_WIDTH +: DATA_WIDTH])
//   irq_o        : registered level interrupt, |(reg[IRQ_REG] & reg[IRQ_EN_REG])
module config_regbank
  import config_regbank_pkg::*;
#(
  parameter int unsigned                     DATA_WIDTH  = 32,
  parameter int unsigned                     ADDR_WIDTH  = 4,
  parameter int unsigned                     NUM_REGS    = 16,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VALUE = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RO_MASK     = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  W1C_MASK    = '0,
  parameter int unsigned                     IRQ_REG     = 0,
  parameter int unsigned                     IRQ_EN_REG  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  config_regbank_if.slave                bus,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set_i,
  input  logic [NUM_REGS-1:0]            hw_we_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] mem_expose_o,
  output logic                           irq_o
);

  logic [DATA_WIDTH-1:0] reg_val [NUM_REGS];
  logic                  wr_in_range, rd_in_range;
  logic [DATA_WIDTH-1:0] rd_mux;

  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_err_q, rd_err_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  wr_err_q, wr_err_d;
  logic                  irq_q, irq_d;

  assign wr_in_range = 32'(bus.wr_addr) < NUM_REGS;
  assign rd_in_range = 32'(bus.rd_addr) < NUM_REGS;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam int unsigned Lsb = reg_lsb(i, DATA_WIDTH);

    config_regbank_cell #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE[Lsb +: DATA_WIDTH]),
      .RO_MASK     (RO_MASK[Lsb +: DATA_WIDTH]),
      .W1C_MASK    (W1C_MASK[Lsb +: DATA_WIDTH])
    ) u_cell (
      .clk        (clk),
      .reset      (reset),
      .sw_we_i    (bus.wr_valid && (bus.wr_addr == ADDR_WIDTH'(i))),
      .wr_data_i  (bus.wr_data),
      .wr_strb_i  (bus.wr_strb),
      .hw_set_i   (hw_set_i[Lsb +: DATA_WIDTH]),
      .hw_we_i    (hw_we_i[i]),
      .hw_wdata_i (hw_wdata_i[Lsb +: DATA_WIDTH]),
      .q_o        (reg_val[i])
    );

    assign mem_expose_o[Lsb +: DATA_WIDTH] = reg_val[i];
  end

  // Reads see the registered (pre-write) value of a same-cycle write.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_addr == ADDR_WIDTH'(i)) rd_mux = reg_val[i];
    end
  end

  always_comb begin
    rd_valid_d = bus.rd_req;
    rd_err_d   = bus.rd_req && !rd_in_range;
    rd_data_d  = (bus.rd_req && rd_in_range) ? rd_mux : '0;
    // A zero-strobe write is a null transaction and never flags an error.
    wr_err_d   = bus.wr_valid && (|bus.wr_strb) && !wr_in_range;
    irq_d      = |(reg_val[IRQ_REG] & reg_val[IRQ_EN_REG]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
      wr_err_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
      wr_err_q   <= wr_err_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.wr_err   = wr_err_q;
  assign irq_o        = irq_q;

endmodule
